// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the two-port (ICache/DCache) memory arbiter.
// Holds the FSM states, command priority and line beat count.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwnI,
    StOwnD
  } stateT;

  typedef enum logic [2:0] {
    CmdNone,
    CmdReadWord,
    CmdReadLine,
    CmdWriteWord,
    CmdWriteLine
  } cmdT;

  localparam int unsigned LineBeats = 4;
  localparam logic [1:0]  LastBeat  = 2'(LineBeats - 1);

  // Several command bits at once collapse to the highest-priority one.
  function automatic cmdT pickCmd(input logic writeLine, input logic writeWord,
                                  input logic readLine, input logic readWord);
    cmdT cmd;
    cmd = CmdNone;
    if (writeLine) begin
      cmd = CmdWriteLine;
    end else if (writeWord) begin
      cmd = CmdWriteWord;
    end else if (readLine) begin
      cmd = CmdReadLine;
    end else if (readWord) begin
      cmd = CmdReadWord;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache/memory request bus: the master issues commands, the slave returns data and a Ready strobe.
interface memory_arbiter_if #(
  parameter int PABITS = 32
);
  localparam int W = PABITS - 2;

  logic [W-1:0] Address;
  logic         ReadLine;
  logic         ReadWord;
  logic         WriteLine;
  logic         WriteWord;
  logic [3:0]   WriteBE;
  logic [127:0] Out;
  logic [31:0]  In;
  logic [1:0]   Offset;
  logic         Ready;

  modport master (
    output Address, ReadLine, ReadWord, WriteLine, WriteWord, WriteBE, Out,
    input  In, Offset, Ready
  );

  modport slave (
    input  Address, ReadLine, ReadWord, WriteLine, WriteWord, WriteBE, Out,
    output In, Offset, Ready
  );

endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter granting the single memory port to the ICache or DCache for one
// transaction at a time; commands are latched on grant and never preempted.
module memory_arbiter #(
  parameter int PABITS = 32
) (
  input logic              clock,
  input logic              reset,
  memory_arbiter_if.slave  iBus,
  memory_arbiter_if.slave  dBus,
  memory_arbiter_if.master memBus
);
  import memory_arbiter_pkg::*;

  localparam int W = PABITS - 2;

  stateT        stateQ;
  cmdT          cmdQ;
  logic [W-1:0] addrQ;
  logic [127:0] outQ;
  logic [3:0]   beQ;
  logic [1:0]   beatQ;
  logic         lastD;
  logic         settleQ;

  cmdT  iCmd;
  cmdT  dCmd;
  logic iReq;
  logic dReq;
  logic owned;
  logic done;

  assign iCmd  = pickCmd(iBus.WriteLine, iBus.WriteWord, iBus.ReadLine, iBus.ReadWord);
  assign dCmd  = pickCmd(dBus.WriteLine, dBus.WriteWord, dBus.ReadLine, dBus.ReadWord);
  assign iReq  = iCmd != CmdNone;
  assign dReq  = dCmd != CmdNone;
  assign owned = stateQ != StIdle;
  assign done  = owned && memBus.Ready && ((cmdQ != CmdReadLine) || (beatQ == LastBeat));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ  <= StIdle;
      cmdQ    <= CmdNone;
      addrQ   <= '0;
      outQ    <= '0;
      beQ     <= '0;
      beatQ   <= '0;
      lastD   <= 1'b0;
      settleQ <= 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          // The first idle cycle after a completion ignores requests, so a requester that
          // still holds its command for a cycle after Ready is not served twice.
          if (settleQ) begin
            settleQ <= 1'b0;
          end else if (dReq && (!iReq || !lastD)) begin
            stateQ <= StOwnD;
            cmdQ   <= dCmd;
            addrQ  <= dBus.Address;
            outQ   <= dBus.Out;
            beQ    <= dBus.WriteBE;
            beatQ  <= '0;
            lastD  <= 1'b1;
          end else if (iReq) begin
            stateQ <= StOwnI;
            cmdQ   <= iCmd;
            addrQ  <= iBus.Address;
            outQ   <= iBus.Out;
            beQ    <= iBus.WriteBE;
            beatQ  <= '0;
            lastD  <= 1'b0;
          end
        end
        default: begin
          if (memBus.Ready && (cmdQ == CmdReadLine)) begin
            beatQ <= beatQ + 2'd1;
          end
          if (done) begin
            stateQ  <= StIdle;
            cmdQ    <= CmdNone;
            beQ     <= '0;
            settleQ <= 1'b1;
          end
        end
      endcase
    end
  end

  assign memBus.Address   = addrQ;
  assign memBus.Out       = outQ;
  assign memBus.WriteBE   = beQ;
  assign memBus.WriteLine = cmdQ == CmdWriteLine;
  assign memBus.WriteWord = cmdQ == CmdWriteWord;
  assign memBus.ReadLine  = cmdQ == CmdReadLine;
  assign memBus.ReadWord  = cmdQ == CmdReadWord;

  // Memory responses reach only the current owner; Ready seen in idle goes nowhere.
  assign iBus.Ready  = (stateQ == StOwnI) && memBus.Ready;
  assign iBus.In     = (stateQ == StOwnI) ? memBus.In : '0;
  assign iBus.Offset = (stateQ == StOwnI) ? memBus.Offset : '0;
  assign dBus.Ready  = (stateQ == StOwnD) && memBus.Ready;
  assign dBus.In     = (stateQ == StOwnD) ? memBus.In : '0;
  assign dBus.Offset = (stateQ == StOwnD) ? memBus.Offset : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: grant latency, line beats, round-robin ties,
// held commands, mid-transaction reset and command priority.
module tb_memory_arbiter;

  localparam int PABITS = 32;
  localparam int W = PABITS - 2;

  logic clock;
  logic reset;
  int   errors   = 0;
  int   checks   = 0;
  int   iPulses  = 0;
  int   dPulses  = 0;
  int   wlIssues = 0;
  logic wlPrev   = 1'b0;

  memory_arbiter_if #(.PABITS(PABITS)) iBus ();
  memory_arbiter_if #(.PABITS(PABITS)) dBus ();
  memory_arbiter_if #(.PABITS(PABITS)) memBus ();

  memory_arbiter #(.PABITS(PABITS)) dut (
    .clock (clock),
    .reset (reset),
    .iBus  (iBus),
    .dBus  (dBus),
    .memBus(memBus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) begin
    if (iBus.Ready) iPulses++;
    if (dBus.Ready) dPulses++;
    if (memBus.WriteLine && !wlPrev) wlIssues++;
    wlPrev = memBus.WriteLine;
  end

  // {WriteLine, WriteWord, ReadLine, ReadWord}
  function automatic logic [3:0] memCmd();
    return {memBus.WriteLine, memBus.WriteWord, memBus.ReadLine, memBus.ReadWord};
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clearInputs();
    iBus.Address = '0; iBus.ReadLine = 0; iBus.ReadWord = 0; iBus.WriteLine = 0;
    iBus.WriteWord = 0; iBus.WriteBE = '0; iBus.Out = '0;
    dBus.Address = '0; dBus.ReadLine = 0; dBus.ReadWord = 0; dBus.WriteLine = 0;
    dBus.WriteWord = 0; dBus.WriteBE = '0; dBus.Out = '0;
    memBus.In = '0; memBus.Offset = '0; memBus.Ready = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clearInputs();
    iBus.ReadWord = 1'b1;
    iBus.Address = 30'h123;
    memBus.Ready = 1'b1;
    tick();
    tick();
    checks++; if (memCmd() !== 4'b0000) begin errors++; $display("FAIL reset_cmd: got %b want 0000", memCmd()); end
    checks++; if (memBus.Address !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", memBus.Address); end
    checks++; if (memBus.WriteBE !== 4'b0) begin errors++; $display("FAIL reset_be: got %b want 0000", memBus.WriteBE); end
    checks++; if (memBus.Out !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", memBus.Out); end
    checks++; if (iBus.Ready !== 1'b0) begin errors++; $display("FAIL reset_iready: got %b want 0", iBus.Ready); end
    clearInputs();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_read_word();
    int p0 = iPulses;
    int d0 = dPulses;
    iBus.ReadWord = 1'b1;
    iBus.Address = 30'h100;
    #1;
    checks++; if (memCmd() !== 4'b0000) begin errors++; $display("FAIL rw_latency: got %b want 0000", memCmd()); end
    tick();
    checks++; if (memCmd() !== 4'b0001) begin errors++; $display("FAIL rw_cmd: got %b want 0001", memCmd()); end
    checks++; if (memBus.Address !== 30'h100) begin errors++; $display("FAIL rw_addr: got %h want 100", memBus.Address); end
    tick();
    tick();
    memBus.Ready = 1'b1;
    memBus.In = 32'hDEAD_BEEF;
    memBus.Offset = 2'd1;
    #1;
    checks++; if (iBus.Ready !== 1'b1) begin errors++; $display("FAIL rw_iready: got %b want 1", iBus.Ready); end
    checks++; if (iBus.In !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_idata: got %h want deadbeef", iBus.In); end
    checks++; if (iBus.Offset !== 2'd1) begin errors++; $display("FAIL rw_ioffset: got %0d want 1", iBus.Offset); end
    checks++; if (dBus.Ready !== 1'b0) begin errors++; $display("FAIL rw_dready: got %b want 0", dBus.Ready); end
    checks++; if (dBus.In !== 32'h0) begin errors++; $display("FAIL rw_ddata: got %h want 0", dBus.In); end
    tick();
    memBus.Ready = 1'b0;
    iBus.ReadWord = 1'b0;
    #1;
    checks++; if (memCmd() !== 4'b0000) begin errors++; $display("FAIL rw_idle: got %b want 0000", memCmd()); end
    tick();
    checks++; if (iPulses - p0 !== 1) begin errors++; $display("FAIL rw_ipulses: got %0d want 1", iPulses - p0); end
    checks++; if (dPulses - d0 !== 0) begin errors++; $display("FAIL rw_dpulses: got %0d want 0", dPulses - d0); end
    tick();
  endtask

  task automatic test_read_line();
    int d0 = dPulses;
    dBus.ReadLine = 1'b1;
    dBus.Address = 30'h40;
    tick();
    checks++; if (memBus.Address !== 30'h40) begin errors++; $display("FAIL rl_addr: got %h want 40", memBus.Address); end
    for (int b = 0; b < 4; b++) begin
      checks++; if (memCmd() !== 4'b0010) begin errors++; $display("FAIL rl_cmd%0d: got %b want 0010", b, memCmd()); end
      memBus.Ready = 1'b1;
      memBus.Offset = 2'(b);
      memBus.In = 32'hA000_0000 + 32'(b);
      #1;
      checks++; if (dBus.Ready !== 1'b1) begin errors++; $display("FAIL rl_dready%0d: got %b want 1", b, dBus.Ready); end
      checks++; if (dBus.Offset !== 2'(b)) begin errors++; $display("FAIL rl_offset%0d: got %0d want %0d", b, dBus.Offset, b); end
      checks++; if (dBus.In !== 32'hA000_0000 + 32'(b)) begin errors++; $display("FAIL rl_data%0d: got %h want %h", b, dBus.In, 32'hA000_0000 + 32'(b)); end
      tick();
    end
    memBus.Ready = 1'b0;
    dBus.ReadLine = 1'b0;
    #1;
    checks++; if (memCmd() !== 4'b0000) begin errors++; $display("FAIL rl_idle: got %b want 0000", memCmd()); end
    checks++; if (dPulses - d0 !== 4) begin errors++; $display("FAIL rl_dpulses: got %0d want 4", dPulses - d0); end
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    reset = 1'b0;
    tick();
    clearInputs();
    reset = 1'b1;
    tick();
    iBus.ReadLine = 1'b1;
    iBus.Address = 30'h200;
    dBus.WriteWord = 1'b1;
    dBus.WriteBE = 4'b0011;
    dBus.Address = 30'h300;
    dBus.Out = 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D;
    tick();
    checks++; if (memCmd() !== 4'b0100) begin errors++; $display("FAIL rr_first_cmd: got %b want 0100", memCmd()); end
    checks++; if (memBus.WriteBE !== 4'b0011) begin errors++; $display("FAIL rr_be: got %b want 0011", memBus.WriteBE); end
    checks++; if (memBus.Address !== 30'h300) begin errors++; $display("FAIL rr_daddr: got %h want 300", memBus.Address); end
    checks++; if (memBus.Out[31:0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL rr_dout: got %h want cafef00d", memBus.Out[31:0]); end
    memBus.Ready = 1'b1;
    #1;
    checks++; if (dBus.Ready !== 1'b1 || iBus.Ready !== 1'b0) begin errors++; $display("FAIL rr_dready: got d=%b i=%b want d=1 i=0", dBus.Ready, iBus.Ready); end
    tick();
    memBus.Ready = 1'b0;
    dBus.WriteWord = 1'b0;
    #1;
    checks++; if (memCmd() !== 4'b0000) begin errors++; $display("FAIL rr_gap: got %b want 0000", memCmd()); end
    tick();
    tick();
    checks++; if (memCmd() !== 4'b0010 || memBus.Address !== 30'h200) begin errors++; $display("FAIL rr_i_second: got %b/%h want 0010/200", memCmd(), memBus.Address); end
    checks++; if (memBus.WriteBE !== 4'b0000) begin errors++; $display("FAIL rr_i_be: got %b want 0000", memBus.WriteBE); end
    dBus.WriteWord = 1'b1;
    for (int b = 0; b < 4; b++) begin
      memBus.Ready = 1'b1;
      memBus.Offset = 2'(b);
      #1;
      checks++; if (memCmd() !== 4'b0010) begin errors++; $display("FAIL rr_nopreempt%0d: got %b want 0010", b, memCmd()); end
      tick();
    end
    memBus.Ready = 1'b0;
    tick();
    tick();
    checks++; if (memCmd() !== 4'b0100) begin errors++; $display("FAIL rr_tie_d: got %b want 0100", memCmd()); end
    memBus.Ready = 1'b1;
    tick();
    memBus.Ready = 1'b0;
    tick();
    tick();
    checks++; if (memCmd() !== 4'b0010) begin errors++; $display("FAIL rr_tie_i: got %b want 0010", memCmd()); end
    iBus.ReadLine = 1'b0;
    dBus.WriteWord = 1'b0;
    for (int b = 0; b < 4; b++) begin
      memBus.Ready = 1'b1;
      tick();
    end
    memBus.Ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int w0 = wlIssues;
    dBus.WriteLine = 1'b1;
    dBus.Address = 30'h80;
    dBus.Out = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    tick();
    checks++; if (memCmd() !== 4'b1000) begin errors++; $display("FAIL wl_cmd: got %b want 1000", memCmd()); end
    checks++; if (memBus.Out !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin errors++; $display("FAIL wl_out: got %h", memBus.Out); end
    memBus.Ready = 1'b1;
    tick();
    memBus.Ready = 1'b0;
    #1;
    checks++; if (memCmd() !== 4'b0000) begin errors++; $display("FAIL wl_gap: got %b want 0000", memCmd()); end
    tick();
    dBus.WriteLine = 1'b0;
    checks++; if (memCmd() !== 4'b0000) begin errors++; $display("FAIL wl_noreissue: got %b want 0000", memCmd()); end
    tick();
    checks++; if (memCmd() !== 4'b0000) begin errors++; $display("FAIL wl_stays_idle: got %b want 0000", memCmd()); end
    tick();
    checks++; if (wlIssues - w0 !== 1) begin errors++; $display("FAIL wl_issues: got %0d want 1", wlIssues - w0); end
  endtask

  task automatic test_reset_abort();
    int p0 = iPulses;
    iBus.ReadLine = 1'b1;
    iBus.Address = 30'h180;
    tick();
    for (int b = 0; b < 2; b++) begin
      memBus.Ready = 1'b1;
      memBus.Offset = 2'(b);
      memBus.In = 32'h5555_0000 + 32'(b);
      tick();
    end
    memBus.Ready = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (memCmd() !== 4'b0000) begin errors++; $display("FAIL abort_cmd: got %b want 0000", memCmd()); end
    checks++; if (memBus.Address !== '0 || memBus.Out !== '0) begin errors++; $display("FAIL abort_latch: got %h/%h want 0/0", memBus.Address, memBus.Out); end
    checks++; if (iBus.Ready !== 1'b0 || iBus.In !== '0 || iBus.Offset !== '0) begin errors++; $display("FAIL abort_iout: got %b/%h/%0d want 0/0/0", iBus.Ready, iBus.In, iBus.Offset); end
    tick();
    checks++; if (iPulses - p0 !== 2) begin errors++; $display("FAIL abort_pulses: got %0d want 2", iPulses - p0); end
    clearInputs();
    reset = 1'b1;
    tick();
    tick();
    memBus.Ready = 1'b1;
    #1;
    checks++; if (iBus.Ready !== 1'b0 || dBus.Ready !== 1'b0) begin errors++; $display("FAIL stray_ready: got i=%b d=%b want 0/0", iBus.Ready, dBus.Ready); end
    tick();
    checks++; if (memCmd() !== 4'b0000) begin errors++; $display("FAIL stray_cmd: got %b want 0000", memCmd()); end
    memBus.Ready = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    dBus.ReadWord = 1'b1;
    dBus.WriteWord = 1'b1;
    dBus.WriteBE = 4'b1111;
    dBus.Address = 30'h44;
    tick();
    checks++; if (memCmd() !== 4'b0100) begin errors++; $display("FAIL prio_cmd: got %b want 0100", memCmd()); end
    checks++; if (memBus.WriteBE !== 4'b1111) begin errors++; $display("FAIL prio_be: got %b want 1111", memBus.WriteBE); end
    memBus.Ready = 1'b1;
    tick();
    memBus.Ready = 1'b0;
    dBus.ReadWord = 1'b0;
    dBus.WriteWord = 1'b0;
    tick();
    tick();
    checks++; if (memCmd() !== 4'b0000) begin errors++; $display("FAIL prio_idle: got %b want 0000", memCmd()); end
  endtask

  initial begin
    test_reset();
    test_read_word();
    test_read_line();
    test_round_robin();
    test_back_to_back();
    test_reset_abort();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
